tdm_demux_8: RTL

TDM_DEMUX_8 -- requirements
Module: tdm_demux_8

---
 rtl/tdm_demux_8.sv | 80 ++++++++
 1 files changed

// File: rtl/tdm_demux_8.sv
// rtl/tdm_demux_8.sv - serial TDM frame demultiplexer with sync hunt/lock FSM
module tdm_demux_8 #(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [NUM_CH-1:0] ch_out,
  output logic              frame_valid,
  output logic [SEL_W-1:0]  slot_sel,
  output logic              locked,
  output logic              sync_err
);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);

  state_t            state;
  logic [NUM_CH-1:0] shadow;

  // Locked is a decode of the state flop, so it stays a registered output.
  assign locked = (state == LOCKED);

  // Frame FSM: hunt for sync, then fill shadow slot by slot and publish whole frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      shadow      <= '0;
      ch_out      <= '0;
      slot_sel    <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              shadow    <= {{(NUM_CH-1){1'b0}}, din};
              slot_sel  <= SLOT_ONE;
              state     <= LOCKED;
            end
          end
          LOCKED: begin
            if (frame_sync && (slot_sel != '0)) begin
              // Sync arrived mid-frame: drop the partial frame and restart at slot 0.
              sync_err  <= 1'b1;
              shadow    <= {{(NUM_CH-1){1'b0}}, din};
              slot_sel  <= SLOT_ONE;
            end else begin
              shadow[slot_sel] <= din;
              if (slot_sel == LAST_SLOT) begin
                // Last slot goes straight into ch_out so no partial frame is ever visible.
                ch_out      <= {din, shadow[NUM_CH-2:0]};
                frame_valid <= 1'b1;
                slot_sel    <= '0;
              end else begin
                slot_sel    <= slot_sel + SLOT_ONE;
              end
            end
          end
          default: begin
            state    <= HUNT;
            slot_sel <= '0;
          end
        endcase
      end
    end
  end

endmodule
